// File: rtl/iecdrv_frontend_if.sv
// ROM load bus for iecdrv_frontend: one write strobe with address and data, on clk.
interface iecdrv_frontend_if;
  logic        rom_wr;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;

  modport master (output rom_wr, rom_addr, rom_data);
  modport slave  (input  rom_wr, rom_addr, rom_data);
endinterface

// File: rtl/iecdrv_frontend.sv
// Shared front end for up to 4 IEC drive cores: input sync, phase enables, shared ROM, bus combine.
// Optional parallel-port cable logic is built when IECDRV_PARPORT_EN is defined.
module iecdrv_frontend #(
  parameter int NDR         = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               pause,
  input  logic [NDR-1:0]     drv_reset,
  input  logic               iec_atn_i,
  input  logic               iec_data_i,
  input  logic               iec_clk_i,
  input  logic               iec_fclk_i,
  output logic               iec_atn_s,
  output logic               iec_data_s,
  output logic               iec_clk_s,
  output logic               iec_fclk_s,
  input  logic [NDR-1:0]     iec_data_d,
  input  logic [NDR-1:0]     iec_clk_d,
  input  logic [NDR-1:0]     iec_fclk_d,
  output logic               iec_data_o,
  output logic               iec_clk_o,
  output logic               iec_fclk_o,
  output logic [NDR-1:0]     reset_drv,
  output logic [1:0]         ph2_r,
  output logic [1:0]         ph2_f,
  output logic               wd_ce,
  input  logic [15*NDR-1:0]  drv_addr,
  output logic [8*NDR-1:0]   drv_data,
  iecdrv_frontend_if.slave   rom,
  input  logic [NDR-1:0]     led_d,
  output logic [NDR-1:0]     led
`ifdef IECDRV_PARPORT_EN
  ,
  input  logic [8*NDR-1:0]   par_data_d,
  input  logic [NDR-1:0]     par_stb_d,
  output logic [NDR-1:0]     ext_en,
  output logic [7:0]         par_data_o,
  output logic               par_stb_o
`endif
);

  localparam int unsigned N  = (NDR < 1) ? 1 : (NDR > 4) ? 4 : NDR;
  localparam int unsigned SS = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;

  // ---------------- input synchronisers ----------------
  logic [3:0]     iec_sync [SS];
  logic [NDR-1:0] rst_sync [SS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < SS; k++) begin
        iec_sync[k] <= '1;
        rst_sync[k] <= '1;
      end
    end else begin
      iec_sync[0] <= {iec_atn_i, iec_data_i, iec_clk_i, iec_fclk_i};
      rst_sync[0] <= drv_reset;
      for (int unsigned k = 1; k < SS; k++) begin
        iec_sync[k] <= iec_sync[k-1];
        rst_sync[k] <= rst_sync[k-1];
      end
    end
  end

  assign reset_drv = rst_sync[SS-1];

  // ---------------- phase generator ----------------
  logic [3:0] div;
  logic       ena1, ena;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div   <= '0;
      ena1  <= 1'b0;
      ena   <= 1'b0;
      ph2_r <= '0;
      ph2_f <= '0;
      wd_ce <= 1'b0;
    end else begin
      ena1  <= ~pause;
      // ena only follows ena1 away from the div[2:0]==0 decode point, so pulses never get clipped
      if (div[2:0] != 3'd0) ena <= ena1;
      ph2_r <= '0;
      ph2_f <= '0;
      wd_ce <= 1'b0;
      if (ce) begin
        div      <= div + 4'd1;
        ph2_r[0] <= ena & ~div[3] & (div[2:0] == 3'd0);
        ph2_f[0] <= ena &  div[3] & (div[2:0] == 3'd0);
        ph2_r[1] <= ena & ~div[2] & (div[1:0] == 2'd0);
        ph2_f[1] <= ena &  div[2] & (div[1:0] == 2'd0);
        wd_ce    <= ena & ~div[0];
      end
    end
  end

  // ---------------- shared ROM ----------------
  logic [7:0]  rom_mem [32768];
  logic [14:0] mem_a;
  logic [7:0]  rom_q, rom_out;

  // Address register feeds a read register plus an output register: two cycles from mem_a,
  // which lines the data for drive i up with slot i+3.
  always_ff @(posedge clk) begin
    if (rom.rom_wr) rom_mem[rom.rom_addr] <= rom.rom_data;
    rom_q   <= rom_mem[mem_a];
    rom_out <= rom_q;
  end

  // ---------------- size detection ----------------
  logic       r32, r16;
  logic [1:0] rom_sz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r32    <= 1'b1;
      r16    <= 1'b1;
      rom_sz <= 2'b11;
    end else begin
      if (rom.rom_wr && rom.rom_data != 8'h00 && rom.rom_data != 8'hFF)
        {r32, r16} <= rom.rom_addr[14:13];
      rom_sz <= {r32, r32 | r16};
    end
  end

`ifdef IECDRV_PARPORT_EN
  logic empty8k;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      empty8k <= 1'b0;
    end else if (rom.rom_wr) begin
      if (rom.rom_addr == 15'd0) empty8k <= 1'b1;
      if (rom.rom_data != 8'h00 && rom.rom_data != 8'hFF &&
          rom.rom_addr[14:8] != 7'd0 && rom.rom_addr[14:13] == 2'd0)
        empty8k <= 1'b0;
    end
  end
`endif

  // ---------------- ROM arbiter ----------------
  logic [2:0] slot;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot     <= '0;
      mem_a    <= '0;
      drv_data <= '0;
    end else begin
      if (ph2_f[1])           slot <= '0;
      else if (slot != 3'd7)  slot <= slot + 3'd1;
      for (int unsigned i = 0; i < N; i++) begin
        if (slot == 3'(i))
          mem_a <= {drv_addr[15*i+13 +: 2] & rom_sz, drv_addr[15*i +: 13]};
        if (slot == 3'(i + 3))
          drv_data[8*i +: 8] <= rom_out;
      end
    end
  end

  // ---------------- bus combine ----------------
  always_comb begin
    iec_data_o = 1'b1;
    iec_clk_o  = 1'b1;
    iec_fclk_o = 1'b1;
    for (int unsigned i = 0; i < N; i++) begin
      iec_data_o &= iec_data_d[i] | reset_drv[i];
      iec_clk_o  &= iec_clk_d[i]  | reset_drv[i];
      iec_fclk_o &= iec_fclk_d[i] | reset_drv[i];
    end
  end

  assign iec_atn_s  = iec_sync[SS-1][3];
  assign iec_data_s = iec_sync[SS-1][2] & iec_data_o;
  assign iec_clk_s  = iec_sync[SS-1][1] & iec_clk_o;
  assign iec_fclk_s = iec_sync[SS-1][0] & iec_fclk_o;

  assign led = led_d & ~reset_drv;

`ifdef IECDRV_PARPORT_EN
  always_comb begin
    ext_en     = '0;
    par_data_o = 8'hFF;
    par_stb_o  = 1'b1;
    for (int unsigned i = 0; i < N; i++) begin
      ext_en[i] = rom_sz[1] & empty8k & ~reset_drv[i];
      if (ext_en[i]) par_data_o &= par_data_d[8*i +: 8];
      par_stb_o &= par_stb_d[i] | ~ext_en[i];
    end
  end
`endif

endmodule

// File: tb/tb_iecdrv_frontend.sv
// Directed bench for iecdrv_frontend (NDR=2): vector table for the bus combine plus sequences for
// sync latency, phase timing, ROM sharing/size detection and reset.
module tb_iecdrv_frontend;
  localparam int NDR = 2;
  localparam int SS  = 2;

  logic clk = 1'b0;
  logic reset, ce, pause;
  logic [NDR-1:0] drv_reset;
  logic iec_atn_i, iec_data_i, iec_clk_i, iec_fclk_i;
  logic iec_atn_s, iec_data_s, iec_clk_s, iec_fclk_s;
  logic [NDR-1:0] iec_data_d, iec_clk_d, iec_fclk_d;
  logic iec_data_o, iec_clk_o, iec_fclk_o;
  logic [NDR-1:0] reset_drv;
  logic [1:0] ph2_r, ph2_f;
  logic wd_ce;
  logic [15*NDR-1:0] drv_addr;
  logic [8*NDR-1:0] drv_data;
  logic [NDR-1:0] led_d, led;
`ifdef IECDRV_PARPORT_EN
  logic [8*NDR-1:0] par_data_d;
  logic [NDR-1:0] par_stb_d, ext_en;
  logic [7:0] par_data_o;
  logic par_stb_o;
`endif

  iecdrv_frontend_if rom_bus ();

  iecdrv_frontend #(.NDR(NDR), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .ce(ce), .pause(pause), .drv_reset(drv_reset),
    .iec_atn_i(iec_atn_i), .iec_data_i(iec_data_i), .iec_clk_i(iec_clk_i), .iec_fclk_i(iec_fclk_i),
    .iec_atn_s(iec_atn_s), .iec_data_s(iec_data_s), .iec_clk_s(iec_clk_s), .iec_fclk_s(iec_fclk_s),
    .iec_data_d(iec_data_d), .iec_clk_d(iec_clk_d), .iec_fclk_d(iec_fclk_d),
    .iec_data_o(iec_data_o), .iec_clk_o(iec_clk_o), .iec_fclk_o(iec_fclk_o),
    .reset_drv(reset_drv), .ph2_r(ph2_r), .ph2_f(ph2_f), .wd_ce(wd_ce),
    .drv_addr(drv_addr), .drv_data(drv_data), .rom(rom_bus),
    .led_d(led_d), .led(led)
`ifdef IECDRV_PARPORT_EN
    , .par_data_d(par_data_d), .par_stb_d(par_stb_d), .ext_en(ext_en),
    .par_data_o(par_data_o), .par_stb_o(par_stb_o)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] snap();
    return {reset_drv, ph2_r, ph2_f, wd_ce, drv_data, iec_atn_s, iec_data_s, iec_clk_s,
            iec_fclk_s, iec_data_o, iec_clk_o, iec_fclk_o, led};
  endfunction

  localparam logic [31:0] RESET_SNAP = {2'b11, 2'b00, 2'b00, 1'b0, 16'h0000, 4'hF, 3'b111, 2'b00};

  task automatic rom_write(input logic [14:0] a, input logic [7:0] d);
    @(negedge clk);
    rom_bus.rom_wr   = 1'b1;
    rom_bus.rom_addr = a;
    rom_bus.rom_data = d;
    @(negedge clk);
    rom_bus.rom_wr   = 1'b0;
  endtask

  // Wait (bounded) for a 2 MHz falling phase, then let the 8-slot arbiter round complete.
  task automatic wait_round(input string name);
    logic found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ph2_f[1]) begin
        found = 1'b1;
        break;
      end
    end
    chk(name, {63'd0, found}, 64'd1);
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    logic [1:0] drst, clk_d, data_d, fclk_d, led_d;
    logic atn_i, clk_i, data_i, fclk_i;
    logic [10:0] exp; // {atn_s,clk_s,data_s,fclk_s,clk_o,data_o,fclk_o,led[1:0],reset_drv[1:0]}
  } bvec_t;

  bvec_t vecs [6];

  initial begin
    int r0n, f0n, r1n, f1n, wdn, bad, found_r0, npulse;

    vecs[0] = '{drst:2'b00, clk_d:2'b10, data_d:2'b11, fclk_d:2'b11, led_d:2'b11,
                atn_i:1'b0, clk_i:1'b1, data_i:1'b1, fclk_i:1'b1, exp:11'b0011011_11_00};
    vecs[1] = '{drst:2'b01, clk_d:2'b10, data_d:2'b11, fclk_d:2'b01, led_d:2'b11,
                atn_i:1'b1, clk_i:1'b1, data_i:1'b1, fclk_i:1'b1, exp:11'b1110110_10_01};
    vecs[2] = '{drst:2'b00, clk_d:2'b11, data_d:2'b01, fclk_d:2'b11, led_d:2'b11,
                atn_i:1'b1, clk_i:1'b1, data_i:1'b1, fclk_i:1'b0, exp:11'b1100101_11_00};
    vecs[3] = '{drst:2'b00, clk_d:2'b11, data_d:2'b11, fclk_d:2'b10, led_d:2'b01,
                atn_i:1'b0, clk_i:1'b0, data_i:1'b1, fclk_i:1'b1, exp:11'b0010110_01_00};
    vecs[4] = '{drst:2'b10, clk_d:2'b01, data_d:2'b01, fclk_d:2'b00, led_d:2'b11,
                atn_i:1'b1, clk_i:1'b1, data_i:1'b0, fclk_i:1'b1, exp:11'b1100110_01_10};
    vecs[5] = '{drst:2'b11, clk_d:2'b00, data_d:2'b00, fclk_d:2'b00, led_d:2'b11,
                atn_i:1'b0, clk_i:1'b1, data_i:1'b1, fclk_i:1'b1, exp:11'b0111111_00_11};

    reset = 1'b0; ce = 1'b1; pause = 1'b0; drv_reset = '0;
    iec_atn_i = 1'b1; iec_data_i = 1'b1; iec_clk_i = 1'b1; iec_fclk_i = 1'b1;
    iec_data_d = '1; iec_clk_d = '1; iec_fclk_d = '1; led_d = '1;
    drv_addr = '0;
    rom_bus.rom_wr = 1'b0; rom_bus.rom_addr = '0; rom_bus.rom_data = '0;
`ifdef IECDRV_PARPORT_EN
    par_data_d = '1; par_stb_d = '1;
`endif

    // Reset state and synchroniser latency
    repeat (3) @(negedge clk);
    chk("reset_state", {32'd0, snap()}, {32'd0, RESET_SNAP});
    iec_data_i = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("sync_data_1cyc", {63'd0, iec_data_s}, 64'd1);
    chk("sync_rdrv_1cyc", {62'd0, reset_drv}, 64'd3);
    @(negedge clk);
    chk("sync_data_2cyc", {63'd0, iec_data_s}, 64'd0);
    chk("sync_rdrv_2cyc", {62'd0, reset_drv}, 64'd0);
    iec_data_i = 1'b1;

    // Phase timing over a 64-cycle window anchored on a 1 MHz rising pulse
    found_r0 = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ph2_r[0]) begin
        found_r0 = 1;
        break;
      end
    end
    chk("ph_r0_found", 64'(found_r0), 64'd1);
    r0n = 0; f0n = 0; r1n = 0; f1n = 0; wdn = 0; bad = 0;
    for (int k = 0; k < 64; k++) begin
      if (k > 0) @(negedge clk);
      if (ph2_r[0]) begin r0n++; if (k % 16 != 0) bad++; end
      if (ph2_f[0]) begin f0n++; if (k % 16 != 8) bad++; end
      if (ph2_r[1]) begin r1n++; if (k % 8 != 0)  bad++; end
      if (ph2_f[1]) begin f1n++; if (k % 8 != 4)  bad++; end
      if (wd_ce)    begin wdn++; if (k % 2 != 0)  bad++; end
    end
    chk("ph_r0_count", 64'(r0n), 64'd4);
    chk("ph_f0_count", 64'(f0n), 64'd4);
    chk("ph_r1_count", 64'(r1n), 64'd8);
    chk("ph_f1_count", 64'(f1n), 64'd8);
    chk("wd_ce_count", 64'(wdn), 64'd32);
    chk("ph_misaligned", 64'(bad), 64'd0);

    pause = 1'b1;
    repeat (10) @(negedge clk);
    npulse = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (|{ph2_r, ph2_f, wd_ce}) npulse++;
    end
    chk("pause_pulses", 64'(npulse), 64'd0);
    pause = 1'b0;

    // Shared ROM, full 32K image
    rom_write(15'h1234, 8'hA5);
    rom_write(15'h7FFF, 8'h3C);
    drv_addr = {15'h1234, 15'h7FFF};
    wait_round("rom32_round");
    chk("rom32_drv1", {56'd0, drv_data[15:8]}, 64'hA5);
    chk("rom32_drv0", {56'd0, drv_data[7:0]}, 64'h3C);

    // 8K image: last meaningful write in the low 8K, high addresses mirror
    rom_write(15'h7234, 8'h99);
    rom_write(15'h0000, 8'h00);
    rom_write(15'h1234, 8'h77);
    rom_write(15'h1FFF, 8'h55);
    repeat (2) @(negedge clk);
    drv_addr = {15'h1FFF, 15'h7234};
    wait_round("rom8_round");
    chk("rom8_mirror_drv0", {56'd0, drv_data[7:0]}, 64'h77);
    chk("rom8_drv1", {56'd0, drv_data[15:8]}, 64'h55);

    // Bus combine / LED gating vectors
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      drv_reset = vecs[v].drst; iec_clk_d = vecs[v].clk_d; iec_data_d = vecs[v].data_d;
      iec_fclk_d = vecs[v].fclk_d; led_d = vecs[v].led_d;
      iec_atn_i = vecs[v].atn_i; iec_clk_i = vecs[v].clk_i;
      iec_data_i = vecs[v].data_i; iec_fclk_i = vecs[v].fclk_i;
      repeat (SS + 1) @(negedge clk);
      chk($sformatf("bus_vec%0d", v),
          {53'd0, iec_atn_s, iec_clk_s, iec_data_s, iec_fclk_s, iec_clk_o, iec_data_o,
           iec_fclk_o, led, reset_drv},
          {53'd0, vecs[v].exp});
    end
    drv_reset = '0; iec_data_d = '1; iec_clk_d = '1; iec_fclk_d = '1; led_d = '1;
    iec_atn_i = 1'b1; iec_data_i = 1'b1; iec_clk_i = 1'b1; iec_fclk_i = 1'b1;
    repeat (SS + 1) @(negedge clk);

`ifdef IECDRV_PARPORT_EN
    // Parallel cable: image in the upper half with an empty low 8K
    rom_write(15'h0000, 8'h00);
    rom_write(15'h4000, 8'h12);
    rom_write(15'h7FFF, 8'h34);
    repeat (3) @(negedge clk);
    par_data_d = {8'hF0, 8'h0F}; par_stb_d = 2'b11;
    @(negedge clk);
    chk("par_ext_en", {62'd0, ext_en}, 64'd3);
    chk("par_data_both", {56'd0, par_data_o}, 64'h00);
    chk("par_stb_both", {63'd0, par_stb_o}, 64'd1);
    par_stb_d = 2'b01;
    @(negedge clk);
    chk("par_stb_low", {63'd0, par_stb_o}, 64'd0);
    drv_reset = 2'b10;
    repeat (SS + 1) @(negedge clk);
    chk("par_ext_en_rst", {62'd0, ext_en}, 64'd1);
    chk("par_data_one", {56'd0, par_data_o}, 64'h0F);
    chk("par_stb_masked", {63'd0, par_stb_o}, 64'd1);
    drv_reset = '0;
    repeat (SS + 1) @(negedge clk);
`endif

    // Reset while running
    reset = 1'b0;
    @(negedge clk);
    chk("midop_reset", {32'd0, snap()}, {32'd0, RESET_SNAP});
    reset = 1'b1;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
